// File: rtl/comparator_pkg.sv
// Shared types and elaboration helpers for the chunked magnitude comparator.
package comparator_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } cmp_state_t;

  // Chunk counter width; a single-chunk compare still keeps a 1-bit counter.
  function automatic int cnt_width(input int n, input int w);
    int c;
    c = $clog2(n / w);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/comparator_seq_if.sv
// Operand/result valid-ready bundle between the register file, comparator and flag logic.
interface comparator_seq_if #(
  parameter int N = 32
);
  logic         i_valid;
  logic         i_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         is_signed;
  logic         o_valid;
  logic         o_ready;
  logic         lt;
  logic         eq;

  modport master (
    output i_valid, a, b, is_signed, o_ready,
    input  i_ready, o_valid, lt, eq
  );

  modport slave (
    input  i_valid, a, b, is_signed, o_ready,
    output i_ready, o_valid, lt, eq
  );
endinterface

// File: rtl/comparator_seq_adder_n.sv
// Plain N-bit ripple adder with carry in/out, reused here as a chunk subtractor.
module adder_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

endmodule

// File: rtl/comparator_seq.sv
// Multi-cycle signed/unsigned magnitude comparator: subtracts W bits per cycle,
// LSB chunk first, carrying only the borrow between chunks.
module comparator_seq
  import comparator_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input logic             clk,
  input logic             rst,
  comparator_seq_if.slave bus
);

  localparam int NC = N / W;
  localparam int CW = cnt_width(N, W);
  localparam int NS = 2 ** CW;

  generate
    if (N % W != 0) begin : g_bad_width
      $error("comparator_seq: N must be a multiple of W");
    end
  endgenerate

  cmp_state_t     state_reg;
  logic [N-1:0]   a_reg;
  logic [N-1:0]   b_reg;
  logic           signed_reg;
  logic           carry_reg;
  logic           zero_reg;
  logic [CW-1:0]  cnt_reg;
  logic           i_ready_reg;
  logic           o_valid_reg;
  logic           lt_reg;
  logic           eq_reg;

  logic [W-1:0]   a_chunks [NS];
  logic [W-1:0]   b_chunks [NS];
  logic [W-1:0]   a_cur;
  logic [W-1:0]   b_cur;
  logic [W-1:0]   diff;
  logic           c_out;
  logic           chunk_eq;
  logic           zero_next;
  logic           lt_next;
  logic           last_chunk;

  // Counter range is a power of two; slots past the last chunk read as zero.
  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_chunk
      if (gi < NC) begin : g_real
        assign a_chunks[gi] = a_reg[gi*W +: W];
        assign b_chunks[gi] = b_reg[gi*W +: W];
      end else begin : g_pad
        assign a_chunks[gi] = '0;
        assign b_chunks[gi] = '0;
      end
    end
  endgenerate

  assign a_cur = a_chunks[cnt_reg];
  assign b_cur = b_chunks[cnt_reg];

  adder_n #(.N(W)) u_adder (
    .a     (a_cur),
    .b     (~b_cur),
    .c_in  (carry_reg),
    .sum   (diff),
    .c_out (c_out)
  );

  // a + ~b + c equals zero (c=1) or all-ones (c=0) exactly when the chunks match.
  assign chunk_eq   = (diff == {W{~carry_reg}});
  assign zero_next  = zero_reg & chunk_eq;
  assign last_chunk = (cnt_reg == CW'(NC - 1));
  assign lt_next    = (signed_reg && (a_reg[N-1] != b_reg[N-1])) ? a_reg[N-1] : ~c_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      signed_reg  <= 1'b0;
      carry_reg   <= 1'b1;
      zero_reg    <= 1'b1;
      cnt_reg     <= '0;
      i_ready_reg <= 1'b0;
      o_valid_reg <= 1'b0;
      lt_reg      <= 1'b0;
      eq_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          i_ready_reg <= 1'b1;
          if (bus.i_valid && i_ready_reg) begin
            a_reg       <= bus.a;
            b_reg       <= bus.b;
            signed_reg  <= bus.is_signed;
            carry_reg   <= 1'b1;
            zero_reg    <= 1'b1;
            cnt_reg     <= '0;
            i_ready_reg <= 1'b0;
            state_reg   <= S_BUSY;
          end
        end
        S_BUSY: begin
          carry_reg <= c_out;
          zero_reg  <= zero_next;
          cnt_reg   <= cnt_reg + 1'b1;
          if (last_chunk) begin
            lt_reg      <= lt_next;
            eq_reg      <= zero_next;
            o_valid_reg <= 1'b1;
            state_reg   <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.o_ready) begin
            o_valid_reg <= 1'b0;
            lt_reg      <= 1'b0;
            eq_reg      <= 1'b0;
            cnt_reg     <= '0;
            i_ready_reg <= 1'b1;
            state_reg   <= S_IDLE;
          end
        end
        default: begin
          state_reg   <= S_IDLE;
          i_ready_reg <= 1'b0;
          o_valid_reg <= 1'b0;
          lt_reg      <= 1'b0;
          eq_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.i_ready = i_ready_reg;
  assign bus.o_valid = o_valid_reg;
  assign bus.lt      = lt_reg;
  assign bus.eq      = eq_reg;

endmodule

// File: tb/tb_comparator_seq.sv
// Directed bench for comparator_seq: unit 0 is W=8 (4 chunks), unit 1 is W=N=32.
module tb_comparator_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv   [2];
  logic        sg   [2];
  logic        ordy [2];
  logic [31:0] av   [2];
  logic [31:0] bv   [2];
  logic        ir   [2];
  logic        ov   [2];
  logic        lt   [2];
  logic        eq   [2];

  int total = 0;
  int bad   = 0;

  comparator_seq_if #(.N(32)) bus0 ();
  comparator_seq_if #(.N(32)) bus1 ();

  assign bus0.i_valid   = iv[0];
  assign bus0.a         = av[0];
  assign bus0.b         = bv[0];
  assign bus0.is_signed = sg[0];
  assign bus0.o_ready   = ordy[0];
  assign ir[0]          = bus0.i_ready;
  assign ov[0]          = bus0.o_valid;
  assign lt[0]          = bus0.lt;
  assign eq[0]          = bus0.eq;

  assign bus1.i_valid   = iv[1];
  assign bus1.a         = av[1];
  assign bus1.b         = bv[1];
  assign bus1.is_signed = sg[1];
  assign bus1.o_ready   = ordy[1];
  assign ir[1]          = bus1.i_ready;
  assign ov[1]          = bus1.o_valid;
  assign lt[1]          = bus1.lt;
  assign eq[1]          = bus1.eq;

  comparator_seq #(.N(32), .W(8)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  comparator_seq #(.N(32), .W(32)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int u, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic elt, input logic eeq, input string nm);
    int k;
    int lat;
    int exp_lat;
    exp_lat = (u == 0) ? 4 : 1;
    k = 0;
    while (!ir[u] && k < 10) begin
      step();
      k++;
    end
    total++;
    if (ir[u] !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready: got %b want 1", nm, ir[u]);
    end
    av[u] = a; bv[u] = b; sg[u] = s; iv[u] = 1'b1;
    step();
    iv[u] = 1'b0; av[u] = ~a; bv[u] = ~b; sg[u] = ~s;
    total++;
    if (ir[u] !== 1'b0 || ov[u] !== 1'b0) begin
      bad++;
      $display("FAIL %s_busy: got ready=%b valid=%b want 0 0", nm, ir[u], ov[u]);
    end
    lat = 1;
    step();
    while (ov[u] !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    total++;
    if (lat != exp_lat) begin
      bad++;
      $display("FAIL %s_latency: got %0d want %0d", nm, lat, exp_lat);
    end
    total++;
    if (lt[u] !== elt || eq[u] !== eeq) begin
      bad++;
      $display("FAIL %s_result: got lt=%b eq=%b want lt=%b eq=%b", nm, lt[u], eq[u], elt, eeq);
    end
    ordy[u] = 1'b1;
    step();
    ordy[u] = 1'b0;
    total++;
    if (ov[u] !== 1'b0 || lt[u] !== 1'b0 || eq[u] !== 1'b0 || ir[u] !== 1'b1) begin
      bad++;
      $display("FAIL %s_release: got valid=%b lt=%b eq=%b ready=%b want 0 0 0 1",
               nm, ov[u], lt[u], eq[u], ir[u]);
    end
    $display("op %s unit=%0d a=%h b=%h signed=%b lt=%b eq=%b lat=%0d",
             nm, u, a, b, s, elt, eeq, lat);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      iv[u] = 1'b0; sg[u] = 1'b0; ordy[u] = 1'b0; av[u] = '0; bv[u] = '0;
    end
    repeat (3) step();
    for (int u = 0; u < 2; u++) begin
      total++;
      if (ir[u] !== 1'b0 || ov[u] !== 1'b0 || lt[u] !== 1'b0 || eq[u] !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold unit=%0d: got ready=%b valid=%b lt=%b eq=%b want 0 0 0 0",
                 u, ir[u], ov[u], lt[u], eq[u]);
      end
    end
    rst = 1'b1;
    step();
    for (int u = 0; u < 2; u++) begin
      total++;
      if (ir[u] !== 1'b1 || ov[u] !== 1'b0) begin
        bad++;
        $display("FAIL reset_release unit=%0d: got ready=%b valid=%b want 1 0", u, ir[u], ov[u]);
      end
    end
    $display("reset released");
  endtask

  task automatic test_unsigned(input int u);
    do_op(u, 32'd5, 32'd7, 1'b0, 1'b1, 1'b0, "uns_5_7");
    do_op(u, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, "uns_max_1");
  endtask

  task automatic test_signed(input int u);
    do_op(u, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b0, "sgn_m1_1");
    do_op(u, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, "sgn_min_max");
    do_op(u, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, "uns_min_max");
  endtask

  task automatic test_equal_carry(input int u);
    do_op(u, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1, "eq_uns");
    do_op(u, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b1, "eq_sgn");
    do_op(u, 32'h0000_0100, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, "carry_100_ff");
    do_op(u, 32'h0000_00FF, 32'h0000_0100, 1'b0, 1'b1, 1'b0, "carry_ff_100");
  endtask

  task automatic test_backpressure();
    int k;
    k = 0;
    while (!ir[0] && k < 10) begin
      step();
      k++;
    end
    av[0] = 32'd2; bv[0] = 32'd9; sg[0] = 1'b0; iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    k = 0;
    while (ov[0] !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    total++;
    if (ov[0] !== 1'b1) begin
      bad++;
      $display("FAIL bp_valid: got %b want 1", ov[0]);
    end
    av[0] = 32'd40; bv[0] = 32'd1; iv[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (ov[0] !== 1'b1 || lt[0] !== 1'b1 || eq[0] !== 1'b0 || ir[0] !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d: got valid=%b lt=%b eq=%b ready=%b want 1 1 0 0",
                 c, ov[0], lt[0], eq[0], ir[0]);
      end
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    step();
    ordy[0] = 1'b0;
    total++;
    if (ov[0] !== 1'b0 || lt[0] !== 1'b0 || ir[0] !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got valid=%b lt=%b ready=%b want 0 0 1", ov[0], lt[0], ir[0]);
    end
    step();
    total++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      bad++;
      $display("FAIL bp_no_extra_op: got valid=%b ready=%b want 0 1", ov[0], ir[0]);
    end
    $display("backpressure held 5 cycles, released");
  endtask

  task automatic test_abort();
    int k;
    k = 0;
    while (!ir[0] && k < 10) begin
      step();
      k++;
    end
    av[0] = 32'd9; bv[0] = 32'd1; sg[0] = 1'b0; iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    total++;
    if (ov[0] !== 1'b0 || lt[0] !== 1'b0 || eq[0] !== 1'b0 || ir[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy: got valid=%b lt=%b eq=%b ready=%b want 0 0 0 0",
               ov[0], lt[0], eq[0], ir[0]);
    end
    step();
    rst = 1'b1;
    step();
    total++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      bad++;
      $display("FAIL abort_busy_release: got valid=%b ready=%b want 0 1", ov[0], ir[0]);
    end
    av[0] = 32'd1; bv[0] = 32'd5; iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    k = 0;
    while (ov[0] !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    rst = 1'b0;
    #1;
    total++;
    if (ov[0] !== 1'b0 || lt[0] !== 1'b0 || eq[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort_done: got valid=%b lt=%b eq=%b want 0 0 0", ov[0], lt[0], eq[0]);
    end
    step();
    rst = 1'b1;
    step();
    $display("abort in busy and done applied");
    do_op(0, 32'd3, 32'd2, 1'b0, 1'b0, 1'b0, "abort_next_w8");
    do_op(1, 32'd3, 32'd2, 1'b0, 1'b0, 1'b0, "abort_next_w32");
  endtask

  initial begin
    test_reset();
    for (int u = 0; u < 2; u++) begin
      test_unsigned(u);
      test_signed(u);
      test_equal_carry(u);
    end
    test_backpressure();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
